// File: rtl/systolic_pkg.sv
// Shared constants, FSM state type, lane-slice helper and FP32 multiply/add units
// used by every cell of the systolic array.
`define SYS_LANE(vec, i, w) vec[(w)*(i) +: (w)]

package systolic_pkg;

   localparam int unsigned FP32_W = 32;
   localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0000_0000;
   localparam logic [FP32_W-1:0] FP32_ONE  = 32'h3F80_0000;
   localparam logic [FP32_W-1:0] FP32_QNAN = 32'h7FC0_0000;

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, OUT} state_t;

   function automatic logic is_nan(input logic [FP32_W-1:0] v);
      return (v[30:23] == 8'hFF) && (v[22:0] != 23'h0);
   endfunction

   // Round-to-nearest-even multiply; denormal inputs and underflowing results flush to zero.
   function automatic logic [FP32_W-1:0] fp32_mul(input logic [FP32_W-1:0] a,
                                                  input logic [FP32_W-1:0] b);
      logic        s;
      logic        g;
      logic        st;
      logic [47:0] p;
      logic [23:0] m;
      logic [24:0] mr;
      int          e;
      s = a[31] ^ b[31];
      if (is_nan(a) || is_nan(b)) return FP32_QNAN;
      if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
         if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return FP32_QNAN;
         return {s, 8'hFF, 23'h0};
      end
      if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'h0};
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47]) begin
         m  = p[47:24];
         g  = p[23];
         st = |p[22:0];
         e  = e + 1;
      end else begin
         m  = p[46:23];
         g  = p[22];
         st = |p[21:0];
      end
      mr = {1'b0, m} + 25'(g & (st | m[0]));
      if (mr[24]) begin
         mr = mr >> 1;
         e  = e + 1;
      end
      if (e >= 255) return {s, 8'hFF, 23'h0};
      if (e <= 0) return {s, 31'h0};
      return {s, e[7:0], mr[22:0]};
   endfunction

   // Round-to-nearest-even add; 26 guard bits with a sticky LSB keep alignment exact.
   function automatic logic [FP32_W-1:0] fp32_add(input logic [FP32_W-1:0] a,
                                                  input logic [FP32_W-1:0] b);
      logic [31:0] x;
      logic [31:0] y;
      logic [49:0] mx;
      logic [49:0] my;
      logic [50:0] s;
      logic [24:0] mr;
      logic        stk;
      int          d;
      int          e;
      int          lead;
      if (is_nan(a) || is_nan(b)) return FP32_QNAN;
      if (a[30:23] == 8'hFF) return (b[30:23] == 8'hFF && a[31] != b[31]) ? FP32_QNAN : a;
      if (b[30:23] == 8'hFF) return b;
      if (a[30:23] == 8'h00) return (b[30:23] == 8'h00) ? {a[31] & b[31], 31'h0} : b;
      if (b[30:23] == 8'h00) return a;
      if (a[30:0] >= b[30:0]) begin
         x = a;
         y = b;
      end else begin
         x = b;
         y = a;
      end
      d   = int'(x[30:23]) - int'(y[30:23]);
      mx  = {1'b1, x[22:0], 26'h0};
      my  = {1'b1, y[22:0], 26'h0};
      stk = 1'b0;
      if (d > 49) begin
         stk = 1'b1;
         my  = '0;
      end else if (d > 0) begin
         stk = |(my & ((50'd1 << d) - 50'd1));
         my  = my >> d;
      end
      my[0] = my[0] | stk;
      s = (x[31] == y[31]) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});
      if (s == '0) return FP32_ZERO;
      lead = 0;
      for (int i = 0; i < 51; i++) if (s[i]) lead = i;
      e = int'(x[30:23]) + lead - 49;
      if (lead == 50) s = {1'b0, s[50:2], s[1] | s[0]};
      else            s = s << (49 - lead);
      mr = {1'b0, s[49:26]} + 25'(s[25] & ((|s[24:0]) | s[26]));
      if (mr[24]) begin
         mr = mr >> 1;
         e  = e + 1;
      end
      if (e >= 255) return {x[31], 8'hFF, 23'h0};
      if (e <= 0) return {x[31], 31'h0};
      return {x[31], e[7:0], mr[22:0]};
   endfunction

endpackage

// File: rtl/systolic_pe.sv
// One output-stationary FP32 MAC cell: accumulates a*b on each enabled edge and
// forwards a east and b south through registers.
module systolic_pe
   import systolic_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              clr,
   input  logic [FP32_W-1:0] a_in,
   input  logic [FP32_W-1:0] b_in,
   output logic [FP32_W-1:0] a_out,
   output logic [FP32_W-1:0] b_out,
   output logic [FP32_W-1:0] acc
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc   <= FP32_ZERO;
         a_out <= FP32_ZERO;
         b_out <= FP32_ZERO;
      end else if (clr) begin
         acc   <= FP32_ZERO;
         a_out <= FP32_ZERO;
         b_out <= FP32_ZERO;
      end else if (en) begin
         acc   <= fp32_add(acc, fp32_mul(a_in, b_in));
         a_out <= a_in;
         b_out <= b_in;
      end
   end

endmodule

// File: rtl/systolic_mm_nxn.sv
// N x N output-stationary FP32 systolic multiplier with input skew, global stall,
// drain sequencing and row-serial readout.
module systolic_mm_nxn
   import systolic_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned DW = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N*DW-1:0]      a_col,
   input  logic [N*DW-1:0]      b_row,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N*DW-1:0]      out_row,
   output logic [$clog2(N)-1:0] out_row_idx,
   output logic                 busy
);

   localparam int unsigned IW = $clog2(N);
   localparam int unsigned CW = $clog2(2 * N);

   if (DW != FP32_W) begin : g_bad_dw
      $error("systolic_mm_nxn: DW must be 32");
   end
   if (N < 2 || N > 8) begin : g_bad_n
      $error("systolic_mm_nxn: N must be in 2..8");
   end

   state_t        state;
   state_t        state_nx;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;
   logic [IW-1:0] idx_nx;
   logic          advance;
   logic          clr;
   logic          drain;

   // Next-state, counters and array control
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      idx_nx   = out_row_idx;
      advance  = 1'b0;
      clr      = 1'b0;
      drain    = 1'b0;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               advance  = 1'b1;
               cnt_nx   = CW'(1);
               state_nx = FEED;
            end
         end
         FEED: begin
            if (in_valid) begin
               advance = 1'b1;
               if (cnt == CW'(N - 1)) begin
                  cnt_nx   = '0;
                  state_nx = DRAIN;
               end else begin
                  cnt_nx = cnt + CW'(1);
               end
            end
         end
         DRAIN: begin
            advance = 1'b1;
            drain   = 1'b1;
            if (cnt == CW'(2 * N - 3)) begin
               cnt_nx   = '0;
               state_nx = OUT;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         OUT: begin
            if (out_ready) begin
               if (out_row_idx == IW'(N - 1)) begin
                  idx_nx   = '0;
                  clr      = 1'b1;
                  state_nx = IDLE;
               end else begin
                  idx_nx = out_row_idx + IW'(1);
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         out_row_idx <= '0;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         out_row_idx <= idx_nx;
         in_ready    <= (state_nx == IDLE) || (state_nx == FEED);
         out_valid   <= (state_nx == OUT);
         busy        <= (state_nx != IDLE);
      end
   end

   logic [DW-1:0] a_bus [N][N+1];
   logic [DW-1:0] b_bus [N+1][N];
   logic [DW-1:0] acc   [N][N];
   logic [N-1:0]  unused_a_east;
   logic [N-1:0]  unused_b_south;

   // Lane i of A and lane i of B are delayed by i enabled registers before the array edge
   for (genvar i = 0; i < N; i++) begin : g_skew
      logic [DW-1:0] a_lane;
      logic [DW-1:0] b_lane;
      assign a_lane = drain ? FP32_ZERO : `SYS_LANE(a_col, i, DW);
      assign b_lane = drain ? FP32_ZERO : `SYS_LANE(b_row, i, DW);
      assign unused_a_east[i]  = ^a_bus[i][N];
      assign unused_b_south[i] = ^b_bus[N][i];
      if (i == 0) begin : g_direct
         assign a_bus[i][0] = a_lane;
         assign b_bus[0][i] = b_lane;
      end else begin : g_delay
         logic [DW-1:0] a_dl [i];
         logic [DW-1:0] b_dl [i];
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int d = 0; d < i; d++) begin
                  a_dl[d] <= FP32_ZERO;
                  b_dl[d] <= FP32_ZERO;
               end
            end else if (clr) begin
               for (int d = 0; d < i; d++) begin
                  a_dl[d] <= FP32_ZERO;
                  b_dl[d] <= FP32_ZERO;
               end
            end else if (advance) begin
               a_dl[0] <= a_lane;
               b_dl[0] <= b_lane;
               for (int d = 1; d < i; d++) begin
                  a_dl[d] <= a_dl[d-1];
                  b_dl[d] <= b_dl[d-1];
               end
            end
         end
         assign a_bus[i][0] = a_dl[i-1];
         assign b_bus[0][i] = b_dl[i-1];
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         systolic_pe u_pe (
            .clk   (clk),
            .reset (reset),
            .en    (advance),
            .clr   (clr),
            .a_in  (a_bus[i][j]),
            .b_in  (b_bus[i][j]),
            .a_out (a_bus[i][j+1]),
            .b_out (b_bus[i+1][j]),
            .acc   (acc[i][j])
         );
      end
   end

   // Readout mux selected by the registered row index
   always_comb begin
      out_row = '0;
      if (out_valid) begin
         for (int j = 0; j < N; j++) out_row[DW*j +: DW] = acc[out_row_idx][j];
      end
   end

endmodule

// File: tb/tb_systolic_mm_nxn.sv
// Scoreboard bench for systolic_mm_nxn: an N=2 and an N=4 instance share clock and reset.
module tb_systolic_mm_nxn;

   typedef struct {
      logic [127:0] row;
      int           idx;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   logic         iv2 = 1'b0, or2 = 1'b1, ir2, ov2, busy2;
   logic [63:0]  a2 = '0, b2 = '0, row2;
   logic [0:0]   idx2;
   logic         iv4 = 1'b0, or4 = 1'b1, ir4, ov4, busy4;
   logic [127:0] a4 = '0, b4 = '0, row4;
   logic [1:0]   idx4;

   exp_t q2[$];
   exp_t q4[$];
   exp_t m2, m4;
   int   ma[4][4];
   int   mb[4][4];

   systolic_mm_nxn #(.N(2), .DW(32)) u_dut2 (
      .clk(clk), .reset(rst), .in_valid(iv2), .in_ready(ir2), .a_col(a2), .b_row(b2),
      .out_valid(ov2), .out_ready(or2), .out_row(row2), .out_row_idx(idx2), .busy(busy2));

   systolic_mm_nxn #(.N(4), .DW(32)) u_dut4 (
      .clk(clk), .reset(rst), .in_valid(iv4), .in_ready(ir4), .a_col(a4), .b_row(b4),
      .out_valid(ov4), .out_ready(or4), .out_row(row4), .out_row_idx(idx4), .busy(busy4));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      $display("FAIL %s: got timeout/unexpected event expected none", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] i2f(input int n);
      int          p;
      logic [31:0] m;
      if (n == 0) return 32'h0;
      p = 0;
      for (int k = 0; k < 24; k++) if (n[k]) p = k;
      m = 32'(n) << (23 - p);
      return {1'b0, 8'(127 + p), m[22:0]};
   endfunction

   function automatic logic [127:0] calc_row(input int r);
      logic [127:0] row;
      int           s;
      for (int j = 0; j < 4; j++) begin
         s = 0;
         for (int k = 0; k < 4; k++) s += ma[r][k] * mb[k][j];
         row[32*j +: 32] = i2f(s);
      end
      return row;
   endfunction

   task automatic push4();
      exp_t e;
      for (int r = 0; r < 4; r++) begin
         e.row = calc_row(r);
         e.idx = r;
         q4.push_back(e);
      end
   endtask

   task automatic set_mats(input int sel);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            case (sel)
               0: begin ma[i][j] = (i == j) ? 1 : 0; mb[i][j] = 4 * i + j + 1; end
               1: begin ma[i][j] = (i == j) ? 2 : 0; mb[i][j] = 4 * i + j + 1; end
               2: begin ma[i][j] = 1; mb[i][j] = 1; end
               default: begin ma[i][j] = 2; mb[i][j] = 2; end
            endcase
         end
   endtask

   task automatic drive_beat4(input int k);
      for (int i = 0; i < 4; i++) begin
         a4[32*i +: 32] = i2f(ma[i][k]);
         b4[32*i +: 32] = i2f(mb[k][i]);
      end
      iv4 = 1'b1;
   endtask

   task automatic feed4(input int k0, input int gap, output int t0);
      t0 = cyc;
      for (int k = k0; k < 4; k++) begin
         drive_beat4(k);
         tick();
         if (k == k0) t0 = cyc;
         if (gap > 0 && k < 3) begin
            iv4 = 1'b0;
            a4  = '1;
            b4  = '1;
            repeat (gap) tick();
         end
      end
   endtask

   task automatic wait_valid4(input string name, input int t0, input int exp_lat);
      int g = 0;
      while (!ov4 && g < 200) begin
         tick();
         g++;
      end
      if (!ov4) fail_now(name);
      else check(name, 128'(cyc - t0), 128'(exp_lat));
   endtask

   task automatic wait_idle4(input string name);
      int g = 0;
      while (busy4 && g < 200) begin
         tick();
         g++;
      end
      if (busy4) fail_now(name);
   endtask

   // Monitors pop the scoreboard on every output handshake
   always @(negedge clk) begin
      if (!rst && ov2 && or2) begin
         if (q2.size() == 0) fail_now("n2_unexpected_row");
         else begin
            m2 = q2.pop_front();
            check("n2_row", 128'(row2), m2.row);
            check("n2_idx", 128'(idx2), 128'(m2.idx));
         end
      end
      if (!rst && ov4 && or4) begin
         if (q4.size() == 0) fail_now("n4_unexpected_row");
         else begin
            m4 = q4.pop_front();
            check("n4_row", row4, m4.row);
            check("n4_idx", 128'(idx4), 128'(m4.idx));
         end
      end
   end

   initial begin
      int   t0;
      int   lowc;
      int   g;
      exp_t e;

      tick();
      tick();
      rst = 1'b0;
      check("rst_in_ready4", 128'(ir4), 128'(1));
      check("rst_out_valid4", 128'(ov4), 128'(0));
      check("rst_busy4", 128'(busy4), 128'(0));
      check("rst_out_row4", row4, 128'(0));
      check("rst_in_ready2", 128'(ir2), 128'(1));
      check("rst_busy2", 128'(busy2), 128'(0));

      // N=2 directed job
      e.row = 128'({32'h3E80_0000, 32'h3E90_0000}); e.idx = 0; q2.push_back(e);
      e.row = 128'({32'h3E90_0000, 32'h3E00_0000}); e.idx = 1; q2.push_back(e);
      a2 = {32'h3E00_0000, 32'h3F00_0000};
      b2 = {32'h3E80_0000, 32'h3F00_0000};
      iv2 = 1'b1;
      tick();
      a2 = {32'h3F00_0000, 32'h3E80_0000};
      b2 = {32'h3F00_0000, 32'h3E00_0000};
      tick();
      iv2 = 1'b0;
      t0 = cyc;
      g = 0;
      while (!ov2 && g < 50) begin
         tick();
         g++;
      end
      if (!ov2) fail_now("n2_latency");
      else check("n2_latency", 128'(cyc - t0), 128'(2));
      g = 0;
      while (busy2 && g < 50) begin
         tick();
         g++;
      end

      // Identity * B, without and with 3-cycle bubbles
      set_mats(0);
      push4();
      feed4(0, 0, t0);
      iv4 = 1'b0;
      wait_valid4("id_latency_nogap", t0, 9);
      wait_idle4("id_idle_nogap");
      push4();
      feed4(0, 3, t0);
      iv4 = 1'b0;
      wait_valid4("id_latency_gap", t0, 18);
      wait_idle4("id_idle_gap");

      // Backpressure in OUT
      set_mats(1);
      or4 = 1'b0;
      push4();
      feed4(0, 0, t0);
      iv4 = 1'b0;
      wait_valid4("bp_latency", t0, 9);
      for (int c = 0; c < 5; c++) begin
         check("bp_out_valid", 128'(ov4), 128'(1));
         check("bp_idx", 128'(idx4), 128'(0));
         check("bp_row", row4, calc_row(0));
         tick();
      end
      or4 = 1'b1;
      wait_idle4("bp_idle");

      // Reset mid-DRAIN of an all-ones job
      set_mats(2);
      feed4(0, 0, t0);
      iv4 = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("mid_rst_in_ready", 128'(ir4), 128'(1));
      check("mid_rst_out_valid", 128'(ov4), 128'(0));
      check("mid_rst_busy", 128'(busy4), 128'(0));
      check("mid_rst_out_row", row4, 128'(0));
      check("mid_rst_idx", 128'(idx4), 128'(0));
      tick();
      rst = 1'b0;
      set_mats(3);
      push4();
      feed4(0, 0, t0);
      iv4 = 1'b0;
      wait_valid4("after_rst_latency", t0, 9);
      wait_idle4("after_rst_idle");

      // Back-to-back jobs with in_valid held through DRAIN and OUT
      set_mats(0);
      push4();
      feed4(0, 0, t0);
      set_mats(2);
      push4();
      drive_beat4(0);
      lowc = 0;
      while (!ir4 && lowc < 100) begin
         tick();
         lowc++;
      end
      check("b2b_ready_low_cycles", 128'(lowc), 128'(10));
      feed4(0, 0, t0);
      iv4 = 1'b0;
      wait_idle4("b2b_idle");

      repeat (3) tick();
      check("n2_queue_empty", 128'(q2.size()), 128'(0));
      check("n4_queue_empty", 128'(q4.size()), 128'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
